// File: rtl/data_memory_dp.sv
// Dual-port (one write, one read) byte-lane data memory with registered read and
// a self-clearing INIT sweep after reset or on request.
module data_memory_dp #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DEPTH         = 2**ADDRESS_WIDTH
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic                      Clear_Request,
    input  logic                      Write_Enable,
    input  logic [ADDRESS_WIDTH-1:0]  W_address,
    input  logic [DATA_WIDTH/8-1:0]   Byte_Enable,
    input  logic [DATA_WIDTH-1:0]     DATA_WRITE,
    input  logic                      Read_Enable,
    input  logic [ADDRESS_WIDTH-1:0]  R_address,
    output logic [DATA_WIDTH-1:0]     DATA_READ,
    output logic                      Read_Valid,
    output logic                      Busy,
    output logic                      Addr_Error
);

    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_WORD = ADDRESS_WIDTH'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDRESS_WIDTH compares without wrapping.
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_EXT = (ADDRESS_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] init_count_q, init_count_d;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic                  w_in_range, r_in_range;
    logic                  active, wr_hit, rd_acc, err_d;
    logic [IDX_W-1:0]      w_idx, r_idx, init_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign w_in_range = {1'b0, W_address} < DEPTH_EXT;
    assign r_in_range = {1'b0, R_address} < DEPTH_EXT;
    assign w_idx      = W_address[IDX_W-1:0];
    assign r_idx      = R_address[IDX_W-1:0];
    assign init_idx   = init_count_q[IDX_W-1:0];

    // A clear request takes priority over any access in the same cycle.
    assign active = (state_q == StReady) && !Clear_Request;
    assign wr_hit = active && Write_Enable && (|Byte_Enable) && w_in_range;
    assign rd_acc = active && Read_Enable;
    assign err_d  = active && ((Read_Enable && !r_in_range) ||
                               (Write_Enable && (|Byte_Enable) && !w_in_range));
    assign Busy   = (state_q == StInit);

    always_comb begin
        state_d      = state_q;
        init_count_d = init_count_q;
        unique case (state_q)
            StInit: begin
                if (Clear_Request) begin
                    init_count_d = '0;
                end else if (init_count_q == LAST_WORD) begin
                    state_d      = StReady;
                    init_count_d = '0;
                end else begin
                    init_count_d = init_count_q + 1'b1;
                end
            end
            StReady: begin
                if (Clear_Request) begin
                    state_d      = StInit;
                    init_count_d = '0;
                end
            end
            default: begin
                state_d      = StInit;
                init_count_d = '0;
            end
        endcase
    end

    // Write-first bypass: enabled lanes of a same-address write override the stored word.
    always_comb begin
        rd_word = '0;
        if (r_in_range) begin
            rd_word = mem[r_idx];
            if (wr_hit && (W_address == R_address)) begin
                for (int i = 0; i < LANES; i++) begin
                    if (Byte_Enable[i]) begin
                        rd_word[8*i +: 8] = DATA_WRITE[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StInit;
            init_count_q <= '0;
            DATA_READ    <= '0;
            Read_Valid   <= 1'b0;
            Addr_Error   <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_count_q <= init_count_d;
            Read_Valid   <= rd_acc;
            Addr_Error   <= err_d;
            if (rd_acc) begin
                DATA_READ <= rd_word;
            end
        end
    end

    // Array has no reset; the INIT sweep zeroes it.
    always_ff @(posedge Clock) begin
        if (state_q == StInit) begin
            mem[init_idx] <= '0;
        end else if (wr_hit) begin
            for (int i = 0; i < LANES; i++) begin
                if (Byte_Enable[i]) begin
                    mem[w_idx][8*i +: 8] <= DATA_WRITE[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_dp.sv
// Self-checking bench for data_memory_dp (16-bit words, 4-bit address, 12 words).
module tb_data_memory_dp;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 12;

    logic          Clock         = 1'b0;
    logic          Reset_n       = 1'b0;
    logic          Clear_Request = 1'b0;
    logic          Write_Enable  = 1'b0;
    logic [AW-1:0] W_address     = '0;
    logic [1:0]    Byte_Enable   = '0;
    logic [DW-1:0] DATA_WRITE    = '0;
    logic          Read_Enable   = 1'b0;
    logic [AW-1:0] R_address     = '0;
    logic [DW-1:0] DATA_READ;
    logic          Read_Valid;
    logic          Busy;
    logic          Addr_Error;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];

    data_memory_dp #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .DEPTH         (DEPTH)
    ) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .Clear_Request (Clear_Request),
        .Write_Enable  (Write_Enable),
        .W_address     (W_address),
        .Byte_Enable   (Byte_Enable),
        .DATA_WRITE    (DATA_WRITE),
        .Read_Enable   (Read_Enable),
        .R_address     (R_address),
        .DATA_READ     (DATA_READ),
        .Read_Valid    (Read_Valid),
        .Busy          (Busy),
        .Addr_Error    (Addr_Error)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        Write_Enable  = 1'b0;
        Read_Enable   = 1'b0;
        Clear_Request = 1'b0;
        Byte_Enable   = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (Busy && n < 50) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [1:0] be);
        merge = old;
        if (be[0]) merge[7:0] = nw[7:0];
        if (be[1]) merge[15:8] = nw[15:8];
    endfunction

    task automatic test_reset();
        int n;
        logic [DW-1:0] exp;
        idle();
        Reset_n = 1'b0;
        #1;
        checks++;
        if (Busy !== 1'b1 || Read_Valid !== 1'b0 || Addr_Error !== 1'b0 || DATA_READ !== '0) begin
            errors++;
            $display("FAIL reset_state busy=%b valid=%b err=%b data=%h want 1 0 0 0000",
                     Busy, Read_Valid, Addr_Error, DATA_READ);
        end
        tick();
        tick();
        Reset_n = 1'b1;
        wait_ready(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL reset_busy_cycles got %0d want %0d", n, DEPTH);
        end
        clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            Read_Enable = 1'b1;
            R_address   = AW'(i);
            exp_q.push_back(model[i]);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (Read_Valid !== 1'b1 || DATA_READ !== exp) begin
                errors++;
                $display("FAIL reset_sweep addr %0d got %h valid %b want %h", i, DATA_READ,
                         Read_Valid, exp);
            end
        end
        idle();
        tick();
        checks++;
        if (Read_Valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop got %b want 0", Read_Valid);
        end
    endtask

    task automatic test_byte_lanes();
        logic [DW-1:0] exp;
        Write_Enable = 1'b1;
        W_address    = 4'd9;
        DATA_WRITE   = 16'hC5A3;
        Byte_Enable  = 2'b11;
        tick();
        model[9]    = merge(model[9], 16'hC5A3, 2'b11);
        DATA_WRITE  = 16'h00FF;
        Byte_Enable = 2'b01;
        tick();
        model[9] = merge(model[9], 16'h00FF, 2'b01);
        idle();
        Read_Enable = 1'b1;
        R_address   = 4'd9;
        exp_q.push_back(16'hC5FF);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (Read_Valid !== 1'b1 || DATA_READ !== exp) begin
            errors++;
            $display("FAIL byte_lanes got %h valid %b want %h", DATA_READ, Read_Valid, exp);
        end
        idle();
        tick();
        checks++;
        if (Read_Valid !== 1'b0 || DATA_READ !== 16'hC5FF) begin
            errors++;
            $display("FAIL read_hold got %h valid %b want C5FF valid 0", DATA_READ, Read_Valid);
        end
    endtask

    task automatic test_write_first();
        logic [DW-1:0] exp;
        Write_Enable = 1'b1;
        W_address    = 4'd3;
        DATA_WRITE   = 16'h1234;
        Byte_Enable  = 2'b10;
        Read_Enable  = 1'b1;
        R_address    = 4'd3;
        exp_q.push_back(merge(model[3], 16'h1234, 2'b10));
        model[3] = merge(model[3], 16'h1234, 2'b10);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (Read_Valid !== 1'b1 || DATA_READ !== exp || exp !== 16'h1200) begin
            errors++;
            $display("FAIL write_first got %h valid %b want %h", DATA_READ, Read_Valid, exp);
        end
        idle();
        Read_Enable = 1'b1;
        R_address   = 4'd3;
        exp_q.push_back(model[3]);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (Read_Valid !== 1'b1 || DATA_READ !== exp) begin
            errors++;
            $display("FAIL write_first_stored got %h want %h", DATA_READ, exp);
        end
        idle();
    endtask

    task automatic test_addr_error();
        logic [DW-1:0] exp;
        Read_Enable = 1'b1;
        R_address   = 4'd14;
        exp_q.push_back('0);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (Read_Valid !== 1'b1 || DATA_READ !== exp || Addr_Error !== 1'b1) begin
            errors++;
            $display("FAIL oor_read got %h valid %b err %b want 0000 1 1", DATA_READ,
                     Read_Valid, Addr_Error);
        end
        idle();
        tick();
        checks++;
        if (Addr_Error !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_read got %b want 0", Addr_Error);
        end
        Write_Enable = 1'b1;
        W_address    = 4'd15;
        DATA_WRITE   = 16'hFFFF;
        Byte_Enable  = 2'b11;
        tick();
        idle();
        checks++;
        if (Addr_Error !== 1'b1) begin
            errors++;
            $display("FAIL oor_write err got %b want 1", Addr_Error);
        end
        tick();
        checks++;
        if (Addr_Error !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse_write got %b want 0", Addr_Error);
        end
        // Zero byte-enable: no error, no update, even out of range.
        Write_Enable = 1'b1;
        W_address    = 4'd15;
        Byte_Enable  = 2'b00;
        tick();
        Write_Enable = 1'b1;
        W_address    = 4'd9;
        DATA_WRITE   = 16'h5555;
        Byte_Enable  = 2'b00;
        checks++;
        if (Addr_Error !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_err got %b want 0", Addr_Error);
        end
        tick();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            Read_Enable = 1'b1;
            R_address   = AW'(i);
            exp_q.push_back(model[i]);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (Read_Valid !== 1'b1 || DATA_READ !== exp || Addr_Error !== 1'b0) begin
                errors++;
                $display("FAIL oor_sweep addr %0d got %h err %b want %h", i, DATA_READ,
                         Addr_Error, exp);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_clear();
        int n;
        logic [DW-1:0] exp;
        Write_Enable = 1'b1;
        W_address    = 4'd1;
        DATA_WRITE   = 16'h000F;
        Byte_Enable  = 2'b11;
        tick();
        model[1] = 16'h000F;
        idle();
        Clear_Request = 1'b1;
        tick();
        Clear_Request = 1'b0;
        checks++;
        if (Busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_enter busy got %b want 1", Busy);
        end
        Write_Enable = 1'b1;
        W_address    = 4'd2;
        DATA_WRITE   = 16'hAAAA;
        Byte_Enable  = 2'b11;
        Read_Enable  = 1'b1;
        R_address    = 4'd14;
        tick();
        n = 1;
        idle();
        checks++;
        if (Read_Valid !== 1'b0 || Addr_Error !== 1'b0) begin
            errors++;
            $display("FAIL init_ignore valid %b err %b want 0 0", Read_Valid, Addr_Error);
        end
        while (Busy && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL clear_busy_cycles got %0d want %0d", n, DEPTH);
        end
        // Second clear mid-sweep restarts the count.
        Clear_Request = 1'b1;
        tick();
        Clear_Request = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        Clear_Request = 1'b1;
        tick();
        Clear_Request = 1'b0;
        wait_ready(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL clear_restart_cycles got %0d want %0d", n, DEPTH);
        end
        clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            Read_Enable = 1'b1;
            R_address   = AW'(i);
            exp_q.push_back(model[i]);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (Read_Valid !== 1'b1 || DATA_READ !== exp) begin
                errors++;
                $display("FAIL clear_sweep addr %0d got %h want %h", i, DATA_READ, exp);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_init();
        int n;
        logic [DW-1:0] exp;
        Write_Enable = 1'b1;
        W_address    = 4'd5;
        DATA_WRITE   = 16'hBEEF;
        Byte_Enable  = 2'b11;
        tick();
        idle();
        Read_Enable = 1'b1;
        R_address   = 4'd5;
        tick();
        idle();
        #1;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (DATA_READ !== '0 || Read_Valid !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset data %h valid %b busy %b want 0000 0 1", DATA_READ,
                     Read_Valid, Busy);
        end
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        Reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (Busy !== 1'b1) begin
                errors++;
                $display("FAIL reset_hold busy got %b want 1", Busy);
            end
        end
        Reset_n = 1'b1;
        wait_ready(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL mid_init_reset_cycles got %0d want %0d", n, DEPTH);
        end
        clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            Read_Enable = 1'b1;
            R_address   = AW'(i);
            exp_q.push_back(model[i]);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (Read_Valid !== 1'b1 || DATA_READ !== exp) begin
                errors++;
                $display("FAIL reinit_sweep addr %0d got %h want %h", i, DATA_READ, exp);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        int waddr, raddr;
        logic we;
        logic [1:0] be;
        logic [DW-1:0] wd, exp;
        logic exp_err;
        for (int c = 0; c < 60; c++) begin
            we    = 1'($urandom_range(0, 1));
            waddr = $urandom_range(0, 15);
            raddr = ($urandom_range(0, 1) == 1) ? waddr : $urandom_range(0, 15);
            be    = 2'($urandom_range(0, 3));
            wd    = 16'($urandom);
            Write_Enable = we;
            W_address    = AW'(waddr);
            Byte_Enable  = be;
            DATA_WRITE   = wd;
            Read_Enable  = 1'b1;
            R_address    = AW'(raddr);
            if (raddr >= DEPTH) exp = '0;
            else if (we && waddr == raddr) exp = merge(model[raddr], wd, be);
            else exp = model[raddr];
            exp_q.push_back(exp);
            exp_err = (raddr >= DEPTH) || (we && be != 2'b00 && waddr >= DEPTH);
            if (we && waddr < DEPTH) model[waddr] = merge(model[waddr], wd, be);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (Read_Valid !== 1'b1 || DATA_READ !== exp || Addr_Error !== exp_err) begin
                errors++;
                $display("FAIL b2b cyc %0d r%0d w%0d got %h err %b want %h err %b", c, raddr,
                         waddr, DATA_READ, Addr_Error, exp, exp_err);
            end
        end
        idle();
        tick();
    endtask

    initial begin
        clear_model();
        test_reset();
        test_byte_lanes();
        test_write_first();
        test_addr_error();
        test_clear();
        test_reset_mid_init();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
